// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Round-robin common-data-bus arbiter; registers one winning
//            result per cycle onto the broadcast triple (BCEN/BClabel/BCdata).
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LABEL_W = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*LABEL_W-1:0] req_label,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       BCEN,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [DATA_W-1:0]          BCdata,
    output logic                       bad_label,
    output logic [15:0]                bc_count
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic               r_bcen;
    logic [LABEL_W-1:0] r_label;
    logic [DATA_W-1:0]  r_data;
    logic               r_bad;
    logic [15:0]        r_cnt;

    logic [LABEL_W-1:0] w_lbl [NUM_REQ];
    logic [DATA_W-1:0]  w_dat [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_zero;
    logic               w_found_hi;
    logic               w_found_lo;
    logic [c_PTR_W-1:0] w_win_hi;
    logic [c_PTR_W-1:0] w_win_lo;
    logic               w_found;
    logic [c_PTR_W-1:0] w_win;
    logic [c_PTR_W-1:0] w_ptr_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_lbl[gi]  = req_label[gi*LABEL_W +: LABEL_W];
            assign w_dat[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign w_elig[gi] = req_valid[gi] && (w_lbl[gi] != '0);
            assign w_zero[gi] = req_valid[gi] && (w_lbl[gi] == '0);
            assign grant[gi]  = w_found && (w_win == c_PTR_W'(gi));
        end
    endgenerate

    // Rotating priority as two fixed-priority scans: lowest eligible index at
    // or above the pointer wins, otherwise wrap to the lowest eligible index.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[i] && (c_PTR_W'(i) >= r_ptr)) begin
                w_found_hi = 1'b1;
                w_win_hi   = c_PTR_W'(i);
            end
            if (w_elig[i]) begin
                w_found_lo = 1'b1;
                w_win_lo   = c_PTR_W'(i);
            end
        end
    end

    assign w_found   = w_found_hi | w_found_lo;
    assign w_win     = w_found_hi ? w_win_hi : w_win_lo;
    assign w_ptr_nxt = (w_win == c_PTR_W'(NUM_REQ - 1)) ? '0 : (w_win + c_PTR_W'(1));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_ptr   <= '0;
            r_bcen  <= 1'b0;
            r_label <= '0;
            r_data  <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_bcen <= w_found;
            if (w_found) begin
                r_label <= w_lbl[w_win];
                r_data  <= w_dat[w_win];
                r_ptr   <= w_ptr_nxt;
                r_cnt   <= r_cnt + 16'd1;
            end
            if (|w_zero) begin
                r_bad <= 1'b1;
            end
        end
    end

    assign BCEN      = r_bcen;
    assign BClabel   = r_label;
    assign BCdata    = r_data;
    assign bad_label = r_bad;
    assign bc_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized handshake traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int LW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            RST = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*LW-1:0] req_label = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    grant;
    logic            BCEN;
    logic [LW-1:0]   BClabel;
    logic [DW-1:0]   BCdata;
    logic            bad_label;
    logic [15:0]     bc_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(N), .LABEL_W(LW), .DATA_W(DW)) dut (
        .clk       (clk),
        .RST       (RST),
        .req_valid (req_valid),
        .req_label (req_label),
        .req_data  (req_data),
        .grant     (grant),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .bad_label (bad_label),
        .bc_count  (bc_count)
    );

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*LW-1:0] labels;
        logic [DW-1:0]   base;
        logic [N-1:0]    exp_grant;
        logic            exp_bcen;
        logic [LW-1:0]   exp_label;
        logic [DW-1:0]   exp_data;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*LW-1:0] lbls(input int l3, input int l2, input int l1, input int l0);
        return {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
    endfunction

    task automatic set_in(input logic [N-1:0] v, input logic [N*LW-1:0] l, input logic [DW-1:0] base);
        req_valid = v;
        req_label = l;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + DW'(i);
    endtask

    // Leaves the bench at posedge+1 with the DUT freshly reset.
    task automatic do_reset();
        set_in('0, '0, '0);
        @(negedge clk) RST = 1'b1;
        @(negedge clk) RST = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the requesters in search order from ptr with modulo arithmetic.
    function automatic int ref_winner(input logic [N-1:0] v, input logic [N*LW-1:0] l, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx] && (l[idx*LW +: LW] != '0)) return idx;
        end
        return -1;
    endfunction

    // Random-phase model state and requester state
    int              m_ptr;
    logic            m_bcen;
    logic [LW-1:0]   m_label;
    logic [DW-1:0]   m_data;
    logic            m_bad;
    logic [15:0]     m_cnt;
    logic [N-1:0]    hv;
    logic [LW-1:0]   hl [N];
    logic [DW-1:0]   hd [N];
    logic [N*LW-1:0] pl;
    logic [N*DW-1:0] pd;
    int              gw;
    int              mw;
    logic [N-1:0]    eg;
    logic [N-1:0]    cv;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        tv[0] = '{4'b0010, lbls(0, 0, 7, 0),  32'hDEADBEEE, 4'b0010, 1'b1, 5'd7,  32'hDEADBEEF};
        tv[1] = '{4'b0000, lbls(0, 0, 0, 0),  32'h0000_0000, 4'b0000, 1'b0, 5'd7,  32'hDEADBEEF};
        tv[2] = '{4'b1111, lbls(4, 3, 2, 1),  32'h0000_1000, 4'b0100, 1'b1, 5'd3,  32'h0000_1002};
        tv[3] = '{4'b0011, lbls(0, 0, 6, 5),  32'h0000_2000, 4'b0001, 1'b1, 5'd5,  32'h0000_2000};
        tv[4] = '{4'b1001, lbls(2, 0, 0, 1),  32'h0000_3000, 4'b1000, 1'b1, 5'd2,  32'h0000_3003};
        tv[5] = '{4'b1000, lbls(9, 0, 0, 0),  32'h0000_4000, 4'b1000, 1'b1, 5'd9,  32'h0000_4003};
        tv[6] = '{4'b1000, lbls(10, 0, 0, 0), 32'h0000_5000, 4'b1000, 1'b1, 5'd10, 32'h0000_5003};
        tv[7] = '{4'b0101, lbls(0, 8, 0, 3),  32'h0000_6000, 4'b0001, 1'b1, 5'd3,  32'h0000_6000};

        // ---- vector table ----
        do_reset();
        chk("reset_bcen", BCEN, 0);
        chk("reset_grant", grant, 0);
        for (int r = 0; r < 8; r++) begin
            set_in(tv[r].valid, tv[r].labels, tv[r].base);
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", r), grant, tv[r].exp_grant);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_bcen", r), BCEN, tv[r].exp_bcen);
            chk($sformatf("tbl%0d_label", r), BClabel, tv[r].exp_label);
            chk($sformatf("tbl%0d_data", r), BCdata, tv[r].exp_data);
        end
        chk("tbl_count", bc_count, 7);
        chk("tbl_bad", bad_label, 0);

        // ---- asynchronous reset mid-operation ----
        do_reset();
        set_in(4'b1001, lbls(0, 0, 0, 1), 32'h100);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            set_in(4'b0001, lbls(0, 0, 0, 1), 32'h100);
            @(posedge clk);
            #1;
        end
        chk("prerst_bcen", BCEN, 1);
        chk("prerst_count", bc_count, 5);
        chk("prerst_bad", bad_label, 1);
        #2 RST = 1'b1;
        #1;
        chk("rst_bcen", BCEN, 0);
        chk("rst_label", BClabel, 0);
        chk("rst_data", BCdata, 0);
        chk("rst_count", bc_count, 0);
        chk("rst_bad", bad_label, 0);
        chk("rst_grant_ptr0", grant, 4'b0001);
        @(negedge clk) RST = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_bcen", BCEN, 1);
        chk("postrst_label", BClabel, 1);
        chk("postrst_count", bc_count, 1);

        // ---- contention: all four held until granted ----
        do_reset();
        cv = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            set_in(cv, lbls(4, 3, 2, 1), 32'h7000);
            @(negedge clk);
            chk($sformatf("cont%0d_grant", k), grant, 4'b0001 << k);
            @(posedge clk);
            #1;
            chk($sformatf("cont%0d_bcen", k), BCEN, 1);
            chk($sformatf("cont%0d_label", k), BClabel, k + 1);
            chk($sformatf("cont%0d_data", k), BCdata, 32'h7000 + k);
            cv[k] = 1'b0;
        end
        set_in('0, lbls(4, 3, 2, 1), 32'h7000);
        @(negedge clk);
        chk("cont_idle_grant", grant, 0);
        @(posedge clk);
        #1;
        chk("cont_idle_bcen", BCEN, 0);
        chk("cont_count", bc_count, 4);

        // ---- fairness: requester 0 always valid, requester 2 joins at ptr=1 ----
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in((k == 1) ? 4'b0101 : 4'b0001, lbls(0, 6, 0, 5), 32'h8000);
            @(negedge clk);
            chk($sformatf("fair%0d_grant", k), grant, (k == 1) ? 4'b0100 : 4'b0001);
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d_label", k), BClabel, (k == 1) ? 6 : 5);
        end

        // ---- label 0 is never granted and sets the sticky flag ----
        do_reset();
        set_in(4'b0001, lbls(0, 0, 0, 0), 32'h9000);
        @(negedge clk);
        chk("lbl0_grant", grant, 0);
        @(posedge clk);
        #1;
        chk("lbl0_bcen", BCEN, 0);
        chk("lbl0_bad", bad_label, 1);
        set_in('0, '0, '0);
        @(posedge clk);
        #1;
        chk("lbl0_bad_sticky", bad_label, 1);
        chk("lbl0_bcen_after", BCEN, 0);
        chk("lbl0_count", bc_count, 0);

        // ---- bc_count wrap ----
        do_reset();
        set_in(4'b0001, lbls(0, 0, 0, 1), 32'h0);
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", bc_count, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap_zero", bc_count, 0);
        chk("wrap_bcen", BCEN, 1);
        set_in('0, '0, '0);
        @(posedge clk);
        #1;
        chk("wrap_bcen_off", BCEN, 0);
        chk("wrap_hold", bc_count, 0);

        // ---- randomized handshake traffic against the model ----
        do_reset();
        m_ptr = 0; m_bcen = 0; m_label = '0; m_data = '0; m_bad = 0; m_cnt = '0;
        hv = '0;
        gw = -1;
        for (int i = 0; i < N; i++) begin
            hl[i] = '0;
            hd[i] = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hv[i] || gw == i) begin
                    hv[i] = ($urandom_range(0, 3) != 0);
                    hl[i] = ($urandom_range(0, 63) == 0) ? '0 : LW'($urandom_range(1, 31));
                    hd[i] = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    hv[i] = 1'b0;
                end
                pl[i*LW +: LW] = hl[i];
                pd[i*DW +: DW] = hd[i];
            end
            req_valid = hv;
            req_label = pl;
            req_data  = pd;
            mw = ref_winner(hv, pl, m_ptr);
            eg = (mw >= 0) ? (N'(1) << mw) : '0;
            @(negedge clk);
            chk("rnd_grant", grant, eg);
            @(posedge clk);
            if (mw >= 0) begin
                m_bcen  = 1'b1;
                m_label = hl[mw];
                m_data  = hd[mw];
                m_ptr   = (mw + 1) % N;
                m_cnt   = m_cnt + 16'd1;
            end else begin
                m_bcen = 1'b0;
            end
            for (int i = 0; i < N; i++) if (hv[i] && hl[i] == '0) m_bad = 1'b1;
            #1;
            chk("rnd_bcen", BCEN, m_bcen);
            chk("rnd_label", BClabel, m_label);
            chk("rnd_data", BCdata, m_data);
            chk("rnd_bad", bad_label, m_bad);
            chk("rnd_count", bc_count, m_cnt);
            gw = mw;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
